// File: rtl/uart_reg_master_if.sv
// Request/response bundle between a host and uart_reg_master.
//   req_valid/req_ready : request handshake, accepted when both are high
//   req_write           : 1 = register write, 0 = register read
//   req_addr            : register offset (CR=0 SR=1 DINL=2 DINH=3 DOUTL=4 DOUTH=5)
//   req_wdata           : write data
//   rsp_valid           : one-cycle completion pulse
//   rsp_data            : read data, 0 for writes and errors
//   rsp_err             : invalid address, reply timeout or framing error
// master = request issuer (host/bench), slave = uart_reg_master.
interface uart_reg_master_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [2:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/uart_reg_master.sv
// Host-side initiator for the UART register-access protocol.
// A request is sent as an 8N1 command byte {write, 4'b0000, addr} on sout,
// followed by the data byte for writes. Reads then wait for a one-byte reply
// on sin, bounded by a timeout measured from the end of the command stop bit.
// Ports:
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : request/response bundle (slave modport)
//   busy     : high whenever the transaction FSM is not idle
//   sout     : UART transmit line, idle high
//   sin      : UART receive line, asynchronous to clk
module uart_reg_master #(
  parameter int unsigned CLKS_PER_BIT   = 868,
  parameter int unsigned TIMEOUT_CYCLES = 20 * CLKS_PER_BIT
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_reg_master_if.slave     bus,
  output logic                 busy,
  output logic                 sout,
  input  logic                 sin
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX_CMD,
    S_TX_DATA,
    S_RX_WAIT,
    S_RX_BYTE,
    S_RSP
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] bit_cnt;
  logic [3:0]    bit_idx;     // 0 = start, 1..8 = data, 9 = stop
  logic [7:0]    tx_shift;
  logic [7:0]    wdata_q;
  logic          is_write;
  logic [7:0]    rx_shift;
  logic [TW-1:0] to_cnt;
  logic          sin_meta, sin_sync, sin_prev;
  logic [7:0]    rsp_data_q;
  logic          rsp_err_q;

  logic accept, addr_ok, bit_end, frame_end, rx_edge;

  assign accept    = bus.req_valid && (state == S_IDLE);
  assign addr_ok   = (bus.req_addr <= 3'd5);
  assign bit_end   = (bit_cnt == BIT_LAST);
  assign frame_end = bit_end && (bit_idx == 4'd9);
  // sin_prev follows sin_sync in every state, so a line already low on
  // entry to RX_WAIT never produces an edge.
  assign rx_edge   = sin_prev && !sin_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:
        if (accept) state_d = addr_ok ? S_TX_CMD : S_RSP;
      S_TX_CMD:
        if (frame_end) state_d = is_write ? S_TX_DATA : S_RX_WAIT;
      S_TX_DATA:
        if (frame_end) state_d = S_RSP;
      S_RX_WAIT:
        // The counter reaches TIMEOUT_CYCLES on the edge that leaves RX_WAIT.
        if (rx_edge)                 state_d = S_RX_BYTE;
        else if (to_cnt >= TO_LAST)  state_d = S_RSP;
      S_RX_BYTE:
        if (bit_idx == 4'd0) begin
          if (bit_cnt == HALF_LAST && sin_sync) state_d = S_RX_WAIT;
        end else if (bit_end && bit_idx == 4'd9) begin
          state_d = S_RSP;
        end
      S_RSP:
        state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt    <= '0;
      bit_idx    <= '0;
      tx_shift   <= '0;
      wdata_q    <= '0;
      is_write   <= 1'b0;
      rx_shift   <= '0;
      to_cnt     <= '0;
      sin_meta   <= 1'b1;
      sin_sync   <= 1'b1;
      sin_prev   <= 1'b1;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      sin_meta <= sin;
      sin_sync <= sin_meta;
      sin_prev <= sin_sync;
      case (state)
        S_IDLE: begin
          bit_cnt <= '0;
          bit_idx <= '0;
          if (accept) begin
            tx_shift <= {bus.req_write, 4'b0000, bus.req_addr};
            wdata_q  <= bus.req_wdata;
            is_write <= bus.req_write;
            if (!addr_ok) begin
              rsp_data_q <= '0;
              rsp_err_q  <= 1'b1;
            end
          end
        end
        S_TX_CMD, S_TX_DATA: begin
          to_cnt <= '0;
          if (bit_end) begin
            bit_cnt <= '0;
            if (bit_idx == 4'd9) begin
              bit_idx  <= '0;
              // Preload the data byte so a write continues with no idle gap.
              tx_shift <= wdata_q;
              if (state == S_TX_DATA) begin
                rsp_data_q <= '0;
                rsp_err_q  <= 1'b0;
              end
            end else begin
              bit_idx <= bit_idx + 4'd1;
              if (bit_idx != 4'd0) tx_shift <= tx_shift >> 1;
            end
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        S_RX_WAIT: begin
          bit_cnt <= '0;
          bit_idx <= '0;
          if (to_cnt != TO_MAX) to_cnt <= to_cnt + TW'(1);
          if (state_d == S_RSP) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b1;
          end
        end
        S_RX_BYTE: begin
          // Keeps running so a rejected glitch does not extend the timeout.
          if (to_cnt != TO_MAX) to_cnt <= to_cnt + TW'(1);
          if (bit_idx == 4'd0) begin
            if (bit_cnt == HALF_LAST) begin
              bit_cnt <= '0;
              bit_idx <= 4'd1;
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end else if (bit_end) begin
            bit_cnt <= '0;
            bit_idx <= bit_idx + 4'd1;
            if (bit_idx == 4'd9) begin
              rsp_data_q <= sin_sync ? rx_shift : 8'h00;
              rsp_err_q  <= !sin_sync;
            end else begin
              rx_shift <= {sin_sync, rx_shift[7:1]};
            end
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Decoded from async-reset registers, so sout returns high as soon as rst rises.
  always_comb begin
    sout = 1'b1;
    if (state == S_TX_CMD || state == S_TX_DATA) begin
      if (bit_idx == 4'd0)      sout = 1'b0;
      else if (bit_idx != 4'd9) sout = tx_shift[0];
    end
  end

  assign bus.req_ready = (state == S_IDLE);
  assign bus.rsp_valid = (state == S_RSP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign busy          = (state != S_IDLE);

endmodule
